// File: rtl/demux_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_frame_ctrl_if
//  Description : Handshake and lane-bus bundle between a serial sample
//                source (master) and the demux frame controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_frame_ctrl_if #(
  parameter int WIDTH = 1
);
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 s0;
  logic                 s1;
  logic                 s2;
  logic [8*WIDTH-1:0]   a;
  logic                 busy;
  logic                 frame_valid;
  logic [7:0]           frame_cnt;

  // Source side: issues frames and samples, observes lanes and status
  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, s0, s1, s2, a, busy, frame_valid, frame_cnt
  );

  // Controller side
  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, s0, s1, s2, a, busy, frame_valid, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/demux_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : demux_frame_ctrl
//  Description : Sequencing controller for a 1-to-8 lane demultiplexer.
//                Routes WIDTH-bit samples to lanes 0..7 in scan order, holds
//                them in per-lane registers and pulses frame_valid once the
//                eighth lane has been filled.
//  Options     : DEMUX_CLEAR_ON_START_EN - clear all lanes on IDLE->SCAN
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_frame_ctrl #(
  parameter int WIDTH = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  demux_frame_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q,   idx_d;
  logic [8*WIDTH-1:0]   lanes_q, lanes_d;
  logic [7:0]           cnt_q,   cnt_d;
  logic                 w_accept;

  // Next-state, lane routing and frame counting
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lanes_d  = lanes_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (bus.start && !bus.abort) begin
          state_d = ST_SCAN;
`ifdef DEMUX_CLEAR_ON_START_EN
          lanes_d = '0;
`endif
        end
      end

      ST_SCAN: begin
        // abort wins over a coincident sample, which is dropped
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (bus.in_valid) begin
          w_accept = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q + 8'd1;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase

    // Only the addressed lane is loaded; all others hold
    for (int k = 0; k < 8; k++) begin
      if (w_accept && (idx_q == 3'(k))) begin
        lanes_d[k*WIDTH +: WIDTH] = bus.in_data;
      end
    end
  end

  // State, index, lane and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      lanes_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decode from registered state only
  assign bus.in_ready    = (state_q == ST_SCAN);
  assign bus.busy        = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign bus.frame_valid = (state_q == ST_DONE);
  assign bus.s0          = idx_q[2];
  assign bus.s1          = idx_q[1];
  assign bus.s2          = idx_q[0];
  assign bus.a           = lanes_q;
  assign bus.frame_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_frame_ctrl
//  Description : Self-checking bench for demux_frame_ctrl against a
//                frame-level reference model (sample position, lane array,
//                completed-frame count).
//  Options     : DEMUX_CLEAR_ON_START_EN - model follows the RTL build option
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_frame_ctrl;

  localparam int W  = 1;
  localparam int VW = 14 + 8*W;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  demux_frame_ctrl_if #(.WIDTH(W)) bus ();

  demux_frame_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  bit             m_in_frame;   // collecting samples
  bit             m_complete;   // the single cycle after the 8th sample
  int             m_pos;        // samples collected in current frame
  int             m_frames;     // total completed frames
  logic [W-1:0]   m_lane [8];

  task automatic model_reset();
    m_in_frame = 0;
    m_complete = 0;
    m_pos      = 0;
    m_frames   = 0;
    for (int k = 0; k < 8; k++) m_lane[k] = '0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit v,
                            input logic [W-1:0] d);
    if (!rst_n) begin
      model_reset();
    end else if (m_complete) begin
      m_complete = 0;
      m_frames   = m_frames + 1;
    end else if (!m_in_frame) begin
      if (st && !ab) begin
        m_in_frame = 1;
`ifdef DEMUX_CLEAR_ON_START_EN
        for (int k = 0; k < 8; k++) m_lane[k] = '0;
`endif
      end
    end else if (ab) begin
      m_in_frame = 0;
      m_pos      = 0;
    end else if (v) begin
      m_lane[m_pos] = d;
      m_pos = m_pos + 1;
      if (m_pos == 8) begin
        m_pos      = 0;
        m_in_frame = 0;
        m_complete = 1;
      end
    end
  endtask

  // frame_cnt is compared outside the completion cycle only
  function automatic logic [VW-1:0] exp_vec();
    logic [8*W-1:0] av;
    logic [2:0]     sel;
    logic [7:0]     cnt;
    for (int k = 0; k < 8; k++) av[k*W +: W] = m_lane[k];
    sel = 3'(m_pos);
    cnt = m_complete ? 8'd0 : 8'(m_frames);
    return {m_in_frame, (m_in_frame | m_complete), m_complete,
            sel[2], sel[1], sel[0], av, cnt};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    logic [7:0] cnt;
    cnt = m_complete ? 8'd0 : bus.frame_cnt;
    return {bus.in_ready, bus.busy, bus.frame_valid,
            bus.s0, bus.s1, bus.s2, bus.a, cnt};
  endfunction

  // Drive one cycle of inputs, advance DUT and model, settle past the edge
  task automatic tick(input bit st, input bit ab, input bit v,
                      input logic [W-1:0] d);
    bus.start    = st;
    bus.abort    = ab;
    bus.in_valid = v;
    bus.in_data  = d;
    model_edge(st, ab, v, d);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(0, 0, 0, '0);
    tick(0, 0, 0, '0);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++;
      $display("FAIL reset_state obs=%h exp=%h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(0, 0, 1, '1);
      tests++;
      if (obs_vec() !== exp_vec() || bus.in_ready !== 1'b0) begin
        failed++;
        $display("FAIL idle_after_reset c=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] bits;
    int         pulses;
    bits   = 8'b0100_1101;
    pulses = 0;
    tick(1, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({bus.s0, bus.s1, bus.s2} !== 3'(k) || bus.in_ready !== 1'b1) begin
        failed++;
        $display("FAIL full_sel k=%0d obs=%0d exp=%0d", k, {bus.s0, bus.s1, bus.s2}, k);
      end
      tick(0, 0, 1, W'(bits[k]));
      pulses += int'(bus.frame_valid);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL full_step k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, '0);
    pulses += int'(bus.frame_valid);
    tests++;
    if (bus.a !== 8'b0100_1101 || pulses != 1 || bus.frame_cnt !== 8'd1) begin
      failed++;
      $display("FAIL full_result a=%b pulses=%0d cnt=%0d exp a=01001101 pulses=1 cnt=1",
               bus.a, pulses, bus.frame_cnt);
    end
  endtask

  task automatic test_stalls();
    logic [7:0] bits;
    int         pulses;
    bits   = 8'b0100_1101;
    pulses = 0;
    tick(1, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 1, W'(bits[k]));
      pulses += int'(bus.frame_valid);
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          tick(0, 0, 0, W'(~bits[k]));
          tests++;
          if (obs_vec() !== exp_vec() || {bus.s0, bus.s1, bus.s2} !== 3'd3) begin
            failed++;
            $display("FAIL stall_hold s=%0d obs=%h exp=%h", s, obs_vec(), exp_vec());
          end
        end
      end
    end
    tick(0, 0, 0, '0);
    pulses += int'(bus.frame_valid);
    tests++;
    if (bus.a !== 8'b0100_1101 || pulses != 1 || obs_vec() !== exp_vec()) begin
      failed++;
      $display("FAIL stall_result a=%b pulses=%0d exp a=01001101 pulses=1", bus.a, pulses);
    end
  endtask

  task automatic test_abort();
    logic [7:0] cnt_before;
    cnt_before = bus.frame_cnt;
    tick(1, 0, 0, '0);
    for (int k = 0; k < 5; k++) tick(0, 0, 1, W'($urandom));
    // abort coincident with a valid sample at lane 5
    tick(0, 1, 1, ~m_lane[5]);
    tests++;
    if (obs_vec() !== exp_vec() || bus.busy !== 1'b0 || bus.frame_cnt !== cnt_before) begin
      failed++;
      $display("FAIL abort_state obs=%h exp=%h", obs_vec(), exp_vec());
    end
    tick(0, 0, 0, '0);
    tests++;
    if (obs_vec() !== exp_vec() || bus.frame_valid !== 1'b0) begin
      failed++;
      $display("FAIL abort_no_pulse obs=%h exp=%h", obs_vec(), exp_vec());
    end
    tick(1, 0, 0, '0);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++;
      $display("FAIL restart_lanes obs=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int k = 0; k < 8; k++) tick(0, 0, 1, W'($urandom));
    tick(0, 0, 0, '0);
  endtask

  task automatic test_random();
    bit st, ab, v;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      tick(st, ab, v, W'($urandom));
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL random c=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap_and_start_ignored();
    int  guard;
    bit  saw_wrap;
    logic [7:0] prev;
    saw_wrap = 0;
    guard    = 0;
    while (m_in_frame || m_complete) tick(0, 0, 1, W'($urandom));
    prev = bus.frame_cnt;
    while ((m_frames < 260) && (guard < 400)) begin
      guard++;
      tick(1, 0, 0, '0);
      for (int k = 0; k < 8; k++) begin
        // start pulses mid-frame must not disturb the scan
        tick((k % 3) == 1, 0, 1, W'($urandom));
        tests++;
        if (obs_vec() !== exp_vec()) begin
          failed++;
          $display("FAIL wrap_scan k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
        end
      end
      tick(0, 0, 0, '0);
      if (prev == 8'd255 && bus.frame_cnt == 8'd0) saw_wrap = 1;
      prev = bus.frame_cnt;
      tests++;
      if (bus.frame_cnt !== 8'(m_frames)) begin
        failed++;
        $display("FAIL wrap_cnt obs=%0d exp=%0d", bus.frame_cnt, 8'(m_frames));
      end
    end
    tests++;
    if (!saw_wrap || guard >= 400) begin
      failed++;
      $display("FAIL wrap_seen obs=%0d exp=1 (guard=%0d)", saw_wrap, guard);
    end
  endtask

  task automatic test_reset_mid_frame();
    tick(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) tick(0, 0, 1, '1);
    rst_n = 1'b0;
    tick(0, 0, 1, '1);
    tests++;
    if (obs_vec() !== exp_vec() || bus.a !== '0 || {bus.s0, bus.s1, bus.s2} !== 3'd0
        || bus.busy !== 1'b0 || bus.frame_cnt !== 8'd0) begin
      failed++;
      $display("FAIL reset_mid_frame obs=%h exp=%h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
    tick(0, 0, 0, '0);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++;
      $display("FAIL after_mid_reset obs=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_full_frame();
    test_stalls();
    test_abort();
    test_random();
    test_wrap_and_start_ignored();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
